// File: rtl/dsp_mac_pkg.sv
// Shared types and width/limit helpers for the dsp_mac_pipe slice.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        OP_ADD_ADD = 2'b00,
        OP_ADD_SUB = 2'b01,
        OP_SUB_ADD = 2'b10,
        OP_ACC     = 2'b11
    } opmode_e;

    function automatic int pre_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int prod_w(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic int acc_w(input int dw, input int guard);
        return 2 * dw + 1 + guard;
    endfunction

    function automatic longint sat_max(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/dsp_mac_pipe_sat_shift.sv
// Combinational scale-and-saturate from the AW-bit result to OW bits.
// Round-half-up before the shift when DSP_MAC_ROUND_EN is defined.
module dsp_sat_shift
    import dsp_mac_pkg::*;
#(
    parameter int AW    = 21,
    parameter int OW    = 8,
    parameter int SHIFT = 0
) (
    input  logic signed [AW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 overflow
);

    localparam longint MAX_V = sat_max(OW);
    localparam longint MIN_V = sat_min(OW);

    // One extra bit so the rounding add can never wrap.
    logic signed [AW:0] ext;
    logic signed [AW:0] rnd;
    logic signed [AW:0] shr;
    logic signed [63:0] wide;

    assign ext = {din[AW-1], din};

`ifdef DSP_MAC_ROUND_EN
    if (SHIFT > 0) begin : g_round
        localparam logic [AW:0] HALF = {{AW{1'b0}}, 1'b1} << (SHIFT - 1);
        assign rnd = ext + $signed(HALF);
    end else begin : g_no_round
        assign rnd = ext;
    end
`else
    assign rnd = ext;
`endif

    assign shr  = rnd >>> SHIFT;
    assign wide = 64'(shr);

    always_comb begin
        dout     = shr[OW-1:0];
        overflow = 1'b0;
        if (wide > MAX_V) begin
            dout     = MAX_V[OW-1:0];
            overflow = 1'b1;
        end else if (wide < MIN_V) begin
            dout     = MIN_V[OW-1:0];
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/dsp_mac_pipe.sv
// 3-stage (A+/-D)*B+/-C and framed multiply-accumulate with valid/ready backpressure.
// Optional round-half-up before scaling: define DSP_MAC_ROUND_EN.
module dsp_mac_pipe
    import dsp_mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int OW    = 8,
    parameter int SHIFT = 0,
    parameter int GUARD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] d,
    input  logic signed [DW-1:0] b,
    input  logic signed [DW-1:0] c,
    input  logic [1:0]           opmode,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic signed [OW-1:0] m_tdata,
    output logic                 m_tlast,
    output logic                 overflow
);

    localparam int PW = pre_w(DW);
    localparam int MW = prod_w(DW);
    localparam int AW = acc_w(DW, GUARD);

    logic en;
    assign en       = !m_tvalid || m_tready;
    assign s_tready = en;

    opmode_e            op_in;
    logic signed [PW-1:0] a_x, d_x;
    assign op_in = opmode_e'(opmode);
    assign a_x   = PW'(a);
    assign d_x   = PW'(d);

    logic                 v1, last1;
    opmode_e              op1;
    logic signed [PW-1:0] pre1;
    logic signed [DW-1:0] b1, c1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            op1   <= OP_ADD_ADD;
            pre1  <= '0;
            b1    <= '0;
            c1    <= '0;
        end else if (en) begin
            v1 <= s_tvalid;
            if (s_tvalid) begin
                op1   <= op_in;
                last1 <= s_tlast;
                pre1  <= (op_in == OP_SUB_ADD) ? a_x - d_x : a_x + d_x;
                b1    <= b;
                c1    <= c;
            end
        end
    end

    logic                 v2, last2;
    opmode_e              op2;
    logic signed [MW-1:0] prod2;
    logic signed [DW-1:0] c2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2    <= 1'b0;
            last2 <= 1'b0;
            op2   <= OP_ADD_ADD;
            prod2 <= '0;
            c2    <= '0;
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                op2   <= op1;
                last2 <= last1;
                prod2 <= MW'(pre1) * MW'(b1);
                c2    <= c1;
            end
        end
    end

    logic signed [AW-1:0] acc, prod_x, c_x, base, acc_sum, post, res;
    logic                 frame_open;
    logic                 is_acc, out_v;
    logic signed [OW-1:0] sat_data;
    logic                 sat_ovf;

    assign prod_x  = AW'(prod2);
    assign c_x     = AW'(c2);
    // A closed frame means the next ACC beat starts from zero.
    assign base    = frame_open ? acc : '0;
    assign acc_sum = base + prod_x;
    assign post    = (op2 == OP_ADD_SUB) ? prod_x - c_x : prod_x + c_x;
    assign is_acc  = (op2 == OP_ACC);
    assign res     = is_acc ? acc_sum : post;
    assign out_v   = v2 && (!is_acc || last2);

    dsp_sat_shift #(
        .AW   (AW),
        .OW   (OW),
        .SHIFT(SHIFT)
    ) u_sat (
        .din     (res),
        .dout    (sat_data),
        .overflow(sat_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            overflow   <= 1'b0;
            acc        <= '0;
            frame_open <= 1'b0;
        end else if (en) begin
            m_tvalid <= out_v;
            if (out_v) begin
                m_tdata  <= sat_data;
                m_tlast  <= is_acc ? 1'b1 : last2;
                overflow <= sat_ovf;
            end
            if (v2 && is_acc) begin
                acc        <= acc_sum;
                frame_open <= !last2;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench: two instances (SHIFT=0 and SHIFT=2) share stimulus and a scoreboard.
`timescale 1ns/1ps
module tb_dsp_mac_pipe;

    localparam int DW = 8;
    localparam int OW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                 s_tvalid, s_tlast, m_tready;
    logic signed [DW-1:0] a, d, b, c;
    logic [1:0]           opmode;
    logic                 s_tready, m_tvalid, m_tlast, overflow;
    logic signed [OW-1:0] m_tdata;
    logic                 sh_s_tready, sh_m_tvalid, sh_m_tlast, sh_overflow;
    logic signed [OW-1:0] sh_m_tdata;

    dsp_mac_pipe #(.DW(DW), .OW(OW), .SHIFT(0), .GUARD(4)) u_dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .a(a), .d(d), .b(b), .c(c), .opmode(opmode), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .overflow(overflow)
    );

    dsp_mac_pipe #(.DW(DW), .OW(OW), .SHIFT(2), .GUARD(4)) u_sh (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(sh_s_tready), .s_tlast(s_tlast),
        .a(a), .d(d), .b(b), .c(c), .opmode(opmode), .m_tvalid(sh_m_tvalid), .m_tready(m_tready),
        .m_tdata(sh_m_tdata), .m_tlast(sh_m_tlast), .overflow(sh_overflow)
    );

    typedef struct {
        logic [1:0] op;
        int         a, d, b, c;
        logic       last;
        logic       has_out;
        int         e_data;
        logic       e_ovf;
        logic       e_last;
        int         es_floor;
        int         es_round;
        logic       es_ovf;
    } vec_t;

    typedef struct {
        int   data;
        logic ovf;
        logic last;
        int   sdata;
        logic sovf;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input int op, input int va, input int vd, input int vb, input int vc,
                                input int last, input int has_out, input int e_data, input int e_ovf,
                                input int e_last, input int es_floor, input int es_round, input int es_ovf);
        vec_t v;
        v.op = 2'(op); v.a = va; v.d = vd; v.b = vb; v.c = vc;
        v.last = 1'(last); v.has_out = 1'(has_out);
        v.e_data = e_data; v.e_ovf = 1'(e_ovf); v.e_last = 1'(e_last);
        v.es_floor = es_floor; v.es_round = es_round; v.es_ovf = 1'(es_ovf);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.has_out) begin
            e.data = v.e_data; e.ovf = v.e_ovf; e.last = v.e_last; e.sovf = v.es_ovf;
`ifdef DSP_MAC_ROUND_EN
            e.sdata = v.es_round;
`else
            e.sdata = v.es_floor;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic drive(input vec_t v);
        s_tvalid = 1'b1;
        opmode   = v.op;
        a = DW'(v.a); d = DW'(v.d); b = DW'(v.b); c = DW'(v.c);
        s_tlast  = v.last;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input vec_t v);
        int n = 0;
        drive(v);
        #1;
        while (!s_tready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept", int'(s_tready), 1);
        push_exp(v);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: pops on every handshake, checks hold during stalls.
    initial begin : mon
        exp_t e;
        logic holding;
        int   hd;
        logic hl, ho;
        holding = 1'b0;
        hd = 0; hl = 1'b0; ho = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                holding = 1'b0;
                continue;
            end
            if (m_tvalid && !m_tready) begin
                if (holding) begin
                    check("hold_data", int'(m_tdata), hd);
                    check("hold_last", int'(m_tlast), int'(hl));
                    check("hold_ovf", int'(overflow), int'(ho));
                end else begin
                    holding = 1'b1;
                    hd = int'(m_tdata); hl = m_tlast; ho = overflow;
                end
            end else begin
                holding = 1'b0;
            end
            if (m_tvalid && m_tready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got data %0d with empty scoreboard at %0t", m_tdata, $time);
                end else begin
                    e = sb.pop_front();
                    check("data", int'(m_tdata), e.data);
                    check("ovf", int'(overflow), int'(e.ovf));
                    check("last", int'(m_tlast), int'(e.last));
                    check("sh_valid", int'(sh_m_tvalid), 1);
                    check("sh_data", int'(sh_m_tdata), e.sdata);
                    check("sh_ovf", int'(sh_overflow), int'(e.sovf));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        vec_t acc0, acc1;
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        a = '0; d = '0; b = '0; c = '0; opmode = 2'b00;

        //           op  a    d    b    c  lst out  data ovf lst sflr srnd sovf
        tbl.push_back(mk(0,   3,   2,   4,  5, 0, 1,   25, 0, 0,   6,   6, 0));
        tbl.push_back(mk(1,   3,   2,   4,  5, 1, 1,   15, 0, 1,   3,   4, 0));
        tbl.push_back(mk(2,   3,   2,   4,  5, 0, 1,    9, 0, 0,   2,   2, 0));
        tbl.push_back(mk(0, 127, 127, 127,  0, 0, 1,  127, 1, 0, 127, 127, 1));
        tbl.push_back(mk(0,-128,-128, 127,  0, 0, 1, -128, 1, 0,-128,-128, 1));
        tbl.push_back(mk(0,   1,   0,   6,  0, 0, 1,    6, 0, 0,   1,   2, 0));
        tbl.push_back(mk(1,  -1,   0,   5,  2, 0, 1,   -7, 0, 0,  -2,  -2, 0));
        tbl.push_back(mk(2,  -5,  10,  -3, -7, 0, 1,   38, 0, 0,   9,  10, 0));
        tbl.push_back(mk(0, 127,   0,   1,  0, 0, 1,  127, 0, 0,  31,  32, 0));
        tbl.push_back(mk(0, 127,   0,   1,  1, 0, 1,  127, 1, 0,  32,  32, 0));
        tbl.push_back(mk(1,-128,   0,   1,  0, 0, 1, -128, 0, 0, -32, -32, 0));
        tbl.push_back(mk(1,-128,   0,   1,  1, 0, 1, -128, 1, 0, -33, -32, 0));
        tbl.push_back(mk(3,   1,   1,   5, 99, 0, 0,    0, 0, 0,   0,   0, 0));
        tbl.push_back(mk(3,   1,   1,   5, 99, 0, 0,    0, 0, 0,   0,   0, 0));
        tbl.push_back(mk(3,   1,   1,   5, 99, 0, 0,    0, 0, 0,   0,   0, 0));
        tbl.push_back(mk(3,   1,   1,   5, 99, 1, 1,   40, 0, 1,  10,  10, 0));
        tbl.push_back(mk(3,   2,   1,   3, -4, 0, 0,    0, 0, 0,   0,   0, 0));
        tbl.push_back(mk(3,   2,   1,   3, -4, 1, 1,   18, 0, 1,   4,   5, 0));
        tbl.push_back(mk(3,   1,   0,   7,  0, 0, 0,    0, 0, 0,   0,   0, 0));
        tbl.push_back(mk(0,   3,   2,   4,  5, 1, 1,   25, 0, 1,   6,   6, 0));
        tbl.push_back(mk(3,   1,   0,   7,  0, 1, 1,   14, 0, 1,   3,   4, 0));

        repeat (3) @(negedge clk);
        #2;
        check("rst_m_tvalid", int'(m_tvalid), 0);
        check("rst_m_tdata", int'(m_tdata), 0);
        check("rst_m_tlast", int'(m_tlast), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_s_tready", int'(s_tready), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Latency: count rising edges from the accepting edge to m_tvalid.
        drive(tbl[0]);
        push_exp(tbl[0]);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        cyc = 1;
        while (!m_tvalid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 3);
        @(negedge clk);
        drain();

        // Back-to-back stream, no backpressure.
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
        s_tvalid = 1'b0;
        drain();

        // Same stream with m_tready low for 5 cycles.
        fork
            begin
                for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
                s_tvalid = 1'b0;
            end
            begin
                int n = 0;
                repeat (4) @(negedge clk);
                while (n < 50) begin
                    @(negedge clk);
                    n++;
                    if (m_tvalid) break;
                end
                m_tready = 1'b0;
                #1;
                check("stall_m_tvalid", int'(m_tvalid), 1);
                check("stall_s_tready", int'(s_tready), 0);
                repeat (5) @(negedge clk);
                m_tready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of an accumulate frame discards the partial sum.
        acc0 = mk(3, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        acc1 = mk(3, 1, 1, 5, 0, 1, 1, 20, 0, 1, 5, 5, 0);
        send(acc0);
        send(acc0);
        s_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #2;
        check("mid_rst_m_tvalid", int'(m_tvalid), 0);
        check("mid_rst_m_tdata", int'(m_tdata), 0);
        check("mid_rst_s_tready", int'(s_tready), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(acc0);
        send(acc1);
        s_tvalid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
